// File: rtl/fir_sample_serializer_if.sv
// Sample handshake between the FIR output stage and the serializer.
// The master drives samples; the slave reports whether it can accept one.
interface fir_sample_serializer_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] y_in;
    logic              y_valid;
    logic              y_ready;

    modport master (output y_in, output y_valid, input  y_ready);
    modport slave  (input  y_in, input  y_valid, output y_ready);
endinterface

// File: rtl/fir_sample_serializer.sv
// Buffers FIR output samples in a small FIFO and sends each one as a
// UART-style frame: start bit, DATA_W data bits MSB-first, stop bit.
module fir_sample_serializer #(
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    fir_sample_serializer_if.slave  s_if,
    output logic                    overflow,
    output logic                    tx_out,
    output logic                    busy
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              y_ready_q;
    logic              overflow_q;

    state_e            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] shreg_q;
    logic              tx_q;
    logic              busy_q;

    logic push_s;
    logic pop_s;
    logic baud_end_s;
    logic fifo_ne_s;

    assign push_s     = s_if.y_valid & y_ready_q;
    assign baud_end_s = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign fifo_ne_s  = (count_q != CNT_W'(0));
    // A pop happens only when the FSM is ready to load a new frame.
    assign pop_s      = fifo_ne_s &
                        ((state_q == ST_IDLE) | ((state_q == ST_STOP) & baud_end_s));

    // Next FIFO occupancy from this cycle's push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= s_if.y_in;
        end
    end

    // FIFO pointers, occupancy and the registered ready/overflow flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            y_ready_q  <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q    <= count_d;
            y_ready_q  <= (count_d != CNT_W'(DEPTH));
            overflow_q <= s_if.y_valid & ~y_ready_q;
        end
    end

    // Frame FSM; tx and busy are computed for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    baud_q <= '0;
                    idx_q  <= '0;
                    if (pop_s) begin
                        shreg_q <= mem_q[rd_ptr_q];
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_end_s) begin
                        baud_q  <= '0;
                        idx_q   <= '0;
                        state_q <= ST_DATA;
                        tx_q    <= shreg_q[DATA_W-1];
                    end else begin
                        baud_q  <= baud_q + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_end_s) begin
                        baud_q  <= '0;
                        shreg_q <= shreg_q << 1;
                        if (idx_q == IDX_W'(DATA_W - 1)) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            tx_q    <= shreg_q[DATA_W-2];
                        end
                    end else begin
                        baud_q  <= baud_q + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_end_s) begin
                        baud_q <= '0;
                        if (pop_s) begin
                            shreg_q <= mem_q[rd_ptr_q];
                            state_q <= ST_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_if.y_ready = y_ready_q;
    assign overflow     = overflow_q;
    assign tx_out       = tx_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_fir_sample_serializer.sv
// Bench for fir_sample_serializer: a frame-level reference model (FIFO queue
// plus a position-within-frame timer) predicts the line every cycle.
module tb_fir_sample_serializer;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CPB    = 4;
    localparam int FRAME  = (DATA_W + 2) * CPB;

    logic clk;
    logic rst;
    logic overflow;
    logic tx_out;
    logic busy;

    fir_sample_serializer_if #(.DATA_W(DATA_W)) s_if ();

    fir_sample_serializer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .rst(rst), .s_if(s_if.slave),
        .overflow(overflow), .tx_out(tx_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] cur;
    int                t = -1;
    logic              exp_ovf = 1'b0;
    logic              exp_tx;

    task automatic model_reset();
        q.delete();
        t       = -1;
        exp_ovf = 1'b0;
    endtask

    // One clock: drive inputs, advance the model on the edge, compare at negedge.
    task automatic tick(input logic v, input logic [DATA_W-1:0] d);
        bit rdy;
        bit push;
        s_if.y_valid = v;
        s_if.y_in    = d;
        @(posedge clk);
        rdy     = (q.size() < DEPTH);
        push    = v && rdy;
        exp_ovf = v && !rdy;
        if (t < 0) begin
            if (q.size() > 0) begin cur = q.pop_front(); t = 0; end
        end else if (t == FRAME - 1) begin
            if (q.size() > 0) begin cur = q.pop_front(); t = 0; end
            else t = -1;
        end else begin
            t++;
        end
        if (push) q.push_back(d);
        @(negedge clk);
        if (t < 0)                      exp_tx = 1'b1;
        else if (t < CPB)               exp_tx = 1'b0;
        else if (t < CPB * (DATA_W+1))  exp_tx = cur[DATA_W-1-(t-CPB)/CPB];
        else                            exp_tx = 1'b1;
        checks += 4;
        if (tx_out !== exp_tx) begin
            errors++; $display("FAIL tx_out t=%0d: got %b want %b", t, tx_out, exp_tx);
        end
        if (busy !== (t >= 0)) begin
            errors++; $display("FAIL busy t=%0d: got %b want %b", t, busy, (t >= 0));
        end
        if (s_if.y_ready !== (q.size() < DEPTH)) begin
            errors++; $display("FAIL y_ready: got %b want %b", s_if.y_ready, (q.size() < DEPTH));
        end
        if (overflow !== exp_ovf) begin
            errors++; $display("FAIL overflow: got %b want %b", overflow, exp_ovf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s_if.y_valid = 1'b0;
        s_if.y_in    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (tx_out !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b want 1", tx_out); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (s_if.y_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", s_if.y_ready); end
        if (overflow !== 1'b0)     begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        rst = 1'b1;
        repeat (20) tick(1'b0, '0);
    endtask

    task automatic test_single_frame();
        logic line [0:90];
        int   first_low = -1;
        int   busy_cnt  = 0;
        logic [DATA_W-1:0] decoded;
        tick(1'b1, 16'hA5C3);
        line[1] = tx_out;
        busy_cnt += int'(busy);
        for (int k = 2; k <= 90; k++) begin
            tick(1'b0, '0);
            line[k] = tx_out;
            busy_cnt += int'(busy);
            if (first_low < 0 && tx_out === 1'b0) first_low = k;
        end
        for (int b = 0; b < DATA_W; b++) decoded[DATA_W-1-b] = line[7 + 4*b];
        checks += 4;
        if (first_low != 2)      begin errors++; $display("FAIL single_latency: got %0d want 2", first_low); end
        if (busy_cnt != FRAME)   begin errors++; $display("FAIL single_busy: got %0d want %0d", busy_cnt, FRAME); end
        if (decoded !== 16'hA5C3) begin errors++; $display("FAIL single_data: got %h want a5c3", decoded); end
        if (line[71] !== 1'b1)   begin errors++; $display("FAIL single_stop: got %b want 1", line[71]); end
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0;
        int falls    = 0;
        logic prev_busy = 1'b0;
        tick(1'b1, 16'h0001);
        tick(1'b1, 16'h8000);
        busy_cnt += int'(busy);
        prev_busy = busy;
        repeat (160) begin
            tick(1'b0, '0);
            busy_cnt += int'(busy);
            if (prev_busy && !busy) falls++;
            prev_busy = busy;
        end
        checks += 2;
        if (busy_cnt != 2*FRAME) begin errors++; $display("FAIL b2b_busy: got %0d want %0d", busy_cnt, 2*FRAME); end
        if (falls != 1)          begin errors++; $display("FAIL b2b_gap: got %0d busy falls want 1", falls); end
    endtask

    task automatic test_overflow();
        int ovf_cnt  = 0;
        int busy_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, DATA_W'(i));
            ovf_cnt  += int'(overflow);
            busy_cnt += int'(busy);
        end
        repeat (5*FRAME) begin
            tick(1'b0, '0);
            ovf_cnt  += int'(overflow);
            busy_cnt += int'(busy);
        end
        checks += 2;
        if (ovf_cnt != 3)         begin errors++; $display("FAIL ovf_count: got %0d want 3", ovf_cnt); end
        if (busy_cnt != 5*FRAME)  begin errors++; $display("FAIL ovf_frames: got %0d busy cycles want %0d", busy_cnt, 5*FRAME); end
    endtask

    task automatic test_wrap();
        int ovf_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, DATA_W'(16'h0100 + i));
            ovf_cnt += int'(overflow);
            repeat (FRAME - 1) begin
                tick(1'b0, '0);
                ovf_cnt += int'(overflow);
            end
        end
        repeat (10) tick(1'b0, '0);
        checks++;
        if (ovf_cnt != 0) begin errors++; $display("FAIL wrap_ovf: got %0d want 0", ovf_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        tick(1'b1, DATA_W'($urandom));
        tick(1'b1, DATA_W'($urandom));
        tick(1'b1, DATA_W'($urandom));
        repeat (27) tick(1'b0, '0);
        #1 rst = 1'b0;
        #1;
        checks += 3;
        if (tx_out !== 1'b1)       begin errors++; $display("FAIL midrst_tx: got %b want 1", tx_out); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (s_if.y_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", s_if.y_ready); end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) tick(1'b0, '0);
        tick(1'b1, DATA_W'($urandom));
        repeat (FRAME + 8) tick(1'b0, '0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ((i / 300) % 2 == 0) tick($urandom_range(0, 40) == 0, DATA_W'($urandom));
            else                    tick($urandom_range(0, 3) == 0, DATA_W'($urandom));
        end
        repeat (6*FRAME) tick(1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
